interrupt_service_controller: RTL and testbench

Sequences interrupt service for the 8259A-style PIC. It resolves priority among the masked requests from the Interrupt Request Register and raises INT to the CPU. It runs the two-pulse INTA acknowledge protocol, maintains the In-Service Register (ISR), drives the interrupt vector onto the data bus, and clears ISR bits on EOI. It sits between the IRR and the data bus buffer / control logic.

---
 rtl/interrupt_service_controller.sv | 125 ++++++++++++
 tb/tb_interrupt_service_controller.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/interrupt_service_controller.sv
// interrupt_service_controller: 8259A-style priority resolution, INTA handshake, ISR and EOI handling.
// Optional automatic EOI is compiled in with the ISC_AEOI_EN macro.
module interrupt_service_controller #(
   parameter int VECTOR_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [7:0]              requests,
   input  logic                    INTA_n,
   input  logic [4:0]              vectorBase,
   input  logic                    eoiStrobe,
   input  logic                    eoiSpecific,
   input  logic [2:0]              eoiLevel,
   input  logic                    aeoiMode,
   output logic                    INT,
   output logic                    readPriority,
   output logic [2:0]              resetIRR,
   output logic [7:0]              inServiceReg,
   output logic [VECTOR_WIDTH-1:0] dataBus,
   output logic                    dataBusEnable
);
   typedef enum logic [2:0] {IDLE, PENDING, ACK1, WAIT2, ACK2} state_t;
   state_t                  state_q, state_d;
   logic                    inta_q, spurious_q, spurious_d, int_q, int_d, rp_q, rp_d, dbe_q, dbe_d;
   logic [2:0]              level_q, level_d, reset_irr_q, reset_irr_d, highest;
   logic [7:0]              isr_q, isr_d, eligible, isr_set, eoi_clr, aeoi_clr;
   logic [VECTOR_WIDTH-1:0] data_bus_q, data_bus_d;
   logic                    blocked, any_eligible, fall, rise;
   // A level is eligible only if nothing of equal or higher priority is in service
   always_comb begin
      blocked  = 1'b0;
      eligible = '0;
      highest  = 3'd0;
      for (int n = 0; n < 8; n++) begin
         blocked     = blocked | isr_q[n];
         eligible[n] = requests[n] & ~blocked;
      end
      for (int n = 7; n >= 0; n--) if (eligible[n]) highest = 3'(n);
   end
   assign any_eligible = |eligible;
   assign fall = inta_q & ~INTA_n;
   assign rise = ~inta_q & INTA_n;
   // Non-specific EOI isolates the lowest set ISR bit; an empty ISR yields no clear
   assign eoi_clr = !eoiStrobe ? 8'd0 : eoiSpecific ? 8'd1 << eoiLevel : isr_q & (~isr_q + 8'd1);
`ifdef ISC_AEOI_EN
   assign aeoi_clr = (state_q == ACK2 && rise && aeoiMode && !spurious_q) ? 8'd1 << level_q : 8'd0;
`else
   logic unused_aeoi;
   assign unused_aeoi = aeoiMode;
   assign aeoi_clr    = 8'd0;
`endif
   // Acknowledge sequencer: next state and registered outputs
   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      spurious_d  = spurious_q;
      int_d       = int_q;
      rp_d        = 1'b0;
      reset_irr_d = reset_irr_q;
      data_bus_d  = data_bus_q;
      dbe_d       = dbe_q;
      isr_set     = '0;
      case (state_q)
         IDLE: if (any_eligible) begin
            state_d = PENDING;
            int_d   = 1'b1;
         end
         PENDING: if (fall) begin
            state_d     = ACK1;
            int_d       = 1'b0;
            level_d     = any_eligible ? highest : 3'd7;
            spurious_d  = ~any_eligible;
            rp_d        = any_eligible;
            reset_irr_d = any_eligible ? highest : reset_irr_q;
            isr_set     = any_eligible ? 8'd1 << highest : 8'd0;
         end
         ACK1: if (rise) state_d = WAIT2;
         WAIT2: if (fall) begin
            state_d    = ACK2;
            dbe_d      = 1'b1;
            data_bus_d = VECTOR_WIDTH'({vectorBase, level_q});
         end
         ACK2: if (rise) begin
            state_d    = IDLE;
            dbe_d      = 1'b0;
            data_bus_d = '0;
            spurious_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | isr_set;
   end
   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         inta_q      <= 1'b1;
         level_q     <= 3'd0;
         spurious_q  <= 1'b0;
         int_q       <= 1'b0;
         rp_q        <= 1'b0;
         reset_irr_q <= 3'd0;
         isr_q       <= 8'd0;
         data_bus_q  <= '0;
         dbe_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         inta_q      <= INTA_n;
         level_q     <= level_d;
         spurious_q  <= spurious_d;
         int_q       <= int_d;
         rp_q        <= rp_d;
         reset_irr_q <= reset_irr_d;
         isr_q       <= isr_d;
         data_bus_q  <= data_bus_d;
         dbe_q       <= dbe_d;
      end
   end
   assign INT           = int_q;
   assign readPriority  = rp_q;
   assign resetIRR      = reset_irr_q;
   assign inServiceReg  = isr_q;
   assign dataBus       = data_bus_q;
   assign dataBusEnable = dbe_q;
endmodule

// File: tb/tb_interrupt_service_controller.sv
// tb_interrupt_service_controller: directed checks of acknowledge, nesting, EOI, spurious and reset behaviour.
module tb_interrupt_service_controller;
   logic       clk = 1'b0, reset_n = 1'b0, INTA_n = 1'b1;
   logic [7:0] requests = 8'h00;
   logic [4:0] vectorBase = 5'h11;
   logic       eoiStrobe = 1'b0, eoiSpecific = 1'b0, aeoiMode = 1'b0;
   logic [2:0] eoiLevel = 3'd0;
   logic       INT, readPriority, dataBusEnable;
   logic [2:0] resetIRR;
   logic [7:0] inServiceReg, dataBus;
   int         checks = 0, errors = 0;

   interrupt_service_controller #(.VECTOR_WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .requests(requests), .INTA_n(INTA_n),
      .vectorBase(vectorBase), .eoiStrobe(eoiStrobe), .eoiSpecific(eoiSpecific),
      .eoiLevel(eoiLevel), .aeoiMode(aeoiMode), .INT(INT), .readPriority(readPriority),
      .resetIRR(resetIRR), .inServiceReg(inServiceReg), .dataBus(dataBus),
      .dataBusEnable(dataBusEnable)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic eoi(input logic specific, input logic [2:0] lvl);
      eoiStrobe = 1'b1; eoiSpecific = specific; eoiLevel = lvl;
      tick();
      eoiStrobe = 1'b0;
   endtask

   task automatic do_ack(input string tag, input logic exp_rp, input logic [2:0] exp_lvl,
                         input logic [7:0] exp_isr, input logic [7:0] exp_vec);
      INTA_n = 1'b0; tick();
      check({tag, " readPriority"}, readPriority, exp_rp);
      if (exp_rp) check({tag, " resetIRR"}, resetIRR, exp_lvl);
      check({tag, " isr after ack1"}, inServiceReg, exp_isr);
      check({tag, " INT drop"}, INT, 1'b0);
      INTA_n = 1'b1; tick();
      check({tag, " readPriority width"}, readPriority, 1'b0);
      check({tag, " dbe before ack2"}, dataBusEnable, 1'b0);
      INTA_n = 1'b0; tick();
      check({tag, " dbe ack2"}, dataBusEnable, 1'b1);
      check({tag, " vector"}, dataBus, exp_vec);
      INTA_n = 1'b1; tick();
      check({tag, " dbe end"}, dataBusEnable, 1'b0);
      check({tag, " bus end"}, dataBus, 8'h00);
   endtask

   initial begin
      tick(); tick();
      check("reset INT", INT, 1'b0);
      check("reset rp", readPriority, 1'b0);
      check("reset resetIRR", resetIRR, 3'd0);
      check("reset isr", inServiceReg, 8'h00);
      check("reset bus", dataBus, 8'h00);
      check("reset dbe", dataBusEnable, 1'b0);
      #2 reset_n = 1'b1;
      tick();
      // basic acknowledge
      requests = 8'h08;
      check("basic INT before edge", INT, 1'b0);
      tick();
      check("basic INT", INT, 1'b1);
      do_ack("basic", 1'b1, 3'd3, 8'h08, 8'h8B);
      check("basic isr held", inServiceReg, 8'h08);
      requests = 8'h00;
      eoi(1'b0, 3'd0);
      check("basic eoi", inServiceReg, 8'h00);
      // priority and nesting
      requests = 8'h24;
      tick();
      check("prio INT", INT, 1'b1);
      do_ack("prio", 1'b1, 3'd2, 8'h04, 8'h8A);
      requests = 8'h20;
      tick(); tick();
      check("nested blocked INT", INT, 1'b0);
      eoi(1'b0, 3'd0);
      check("prio eoi isr", inServiceReg, 8'h00);
      tick();
      check("level5 INT", INT, 1'b1);
      do_ack("lvl5", 1'b1, 3'd5, 8'h20, 8'h8D);
      requests = 8'h00;
      eoi(1'b0, 3'd0);
      check("lvl5 eoi", inServiceReg, 8'h00);
      // spurious interrupt
      requests = 8'h01;
      tick();
      check("spur INT", INT, 1'b1);
      requests = 8'h00;
      do_ack("spur", 1'b0, 3'd7, 8'h00, 8'h8F);
      check("spur isr", inServiceReg, 8'h00);
      // specific EOI on a nested ISR
      requests = 8'h08;
      tick();
      do_ack("nest3", 1'b1, 3'd3, 8'h08, 8'h8B);
      requests = 8'h02;
      tick();
      check("nest1 INT", INT, 1'b1);
      do_ack("nest1", 1'b1, 3'd1, 8'h0A, 8'h89);
      requests = 8'h00;
      eoi(1'b1, 3'd3);
      check("specific eoi 3", inServiceReg, 8'h02);
      eoi(1'b1, 3'd5);
      check("specific eoi unset", inServiceReg, 8'h02);
      eoi(1'b0, 3'd0);
      check("nonspecific eoi", inServiceReg, 8'h00);
      eoi(1'b0, 3'd0);
      check("eoi on empty", inServiceReg, 8'h00);
      // automatic EOI
      aeoiMode = 1'b1;
      requests = 8'h10;
      tick();
      do_ack("aeoi", 1'b1, 3'd4, 8'h10, 8'h8C);
      requests = 8'h00;
`ifdef ISC_AEOI_EN
      check("aeoi isr", inServiceReg, 8'h00);
`else
      check("aeoi disabled isr", inServiceReg, 8'h10);
`endif
      aeoiMode = 1'b0;
      eoi(1'b0, 3'd0);
      check("aeoi cleanup", inServiceReg, 8'h00);
      // asynchronous reset during WAIT2
      requests = 8'h40;
      tick();
      INTA_n = 1'b0; tick();
      check("rst isr set", inServiceReg, 8'h40);
      INTA_n = 1'b1; tick();
      #1 reset_n = 1'b0;
      #1;
      check("rst wait2 INT", INT, 1'b0);
      check("rst wait2 dbe", dataBusEnable, 1'b0);
      check("rst wait2 isr", inServiceReg, 8'h00);
      #1 reset_n = 1'b1;
      tick();
      check("restart INT", INT, 1'b1);
      // asynchronous reset during ACK2 with the bus driven
      INTA_n = 1'b0; tick();
      INTA_n = 1'b1; tick();
      INTA_n = 1'b0; tick();
      check("rst ack2 dbe before", dataBusEnable, 1'b1);
      check("rst ack2 bus before", dataBus, 8'h8E);
      #1 reset_n = 1'b0;
      #1;
      check("rst ack2 dbe", dataBusEnable, 1'b0);
      check("rst ack2 bus", dataBus, 8'h00);
      check("rst ack2 isr", inServiceReg, 8'h00);
      INTA_n = 1'b1; requests = 8'h00;
      #1 reset_n = 1'b1;
      tick(); tick();
      check("final INT", INT, 1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
